// File: rtl/seq_pattern_tx.sv
// ============================================================================
//  Module   : seq_pattern_tx
//  Purpose  : MSB-first serial word transmitter with optional overlapping
//             Mealy pattern checker (enabled by defining PAT_CHECK_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_tx #(
    parameter int                 WIDTH   = 16,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_nxt;
    logic [BW-1:0]    r_bitcnt, w_bitcnt_nxt;
    logic             w_x_nxt, w_x_valid_nxt, w_done_nxt;
    logic             w_accept;

    assign load_ready = (r_state == IDLE) || (r_bitcnt == '0);
    assign w_accept   = load_valid && load_ready;
    assign busy       = (r_state == SHIFT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_sh     <= '0;
            r_bitcnt <= '0;
            x        <= 1'b0;
            x_valid  <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sh     <= w_sh_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            x        <= w_x_nxt;
            x_valid  <= w_x_valid_nxt;
            done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sh_nxt      = r_sh;
        w_bitcnt_nxt  = r_bitcnt;
        w_x_nxt       = x;
        w_x_valid_nxt = x_valid;
        w_done_nxt    = 1'b0;

        if (r_state == SHIFT && r_bitcnt != '0) begin
            w_x_nxt      = r_sh[WIDTH-1];
            w_sh_nxt     = r_sh << 1;
            w_bitcnt_nxt = r_bitcnt - BW'(1);
        end else begin
            // Last bit of a word (or idle): either chain the next word or stop.
            if (r_state == SHIFT) begin
                w_done_nxt = 1'b1;
            end
            if (w_accept) begin
                w_x_nxt       = load_data[WIDTH-1];
                w_x_valid_nxt = 1'b1;
                w_sh_nxt      = load_data << 1;
                w_bitcnt_nxt  = BW'(WIDTH - 1);
                w_state_nxt   = SHIFT;
            end else begin
                w_x_nxt       = 1'b0;
                w_x_valid_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
        end
    end

    if (PAT_LEN < 2 || PAT_LEN > WIDTH || WIDTH < 2) begin : g_bad_params
        $error("seq_pattern_tx: illegal WIDTH/PAT_LEN combination");
    end

`ifdef PAT_CHECK_EN
    localparam int HW = $clog2(PAT_LEN);

    logic [PAT_LEN-2:0] r_hist;
    logic [HW-1:0]      r_hcnt;
    logic [PAT_LEN-1:0] w_window;

    assign w_window = {r_hist, x};
    assign match    = x_valid && (r_hcnt == HW'(PAT_LEN - 1)) && (w_window == PATTERN);

    // History is dropped whenever the stream goes idle so matches never bridge gaps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist    <= '0;
            r_hcnt    <= '0;
            match_cnt <= '0;
        end else begin
            if (x_valid) begin
                r_hist <= w_window[PAT_LEN-2:0];
                if (r_hcnt != HW'(PAT_LEN - 1)) begin
                    r_hcnt <= r_hcnt + HW'(1);
                end
            end else begin
                r_hist <= '0;
                r_hcnt <= '0;
            end
            if (match && (match_cnt != {CNT_W{1'b1}})) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign match     = 1'b0;
    assign match_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// ============================================================================
//  Module   : tb_seq_pattern_tx
//  Purpose  : Directed self-checking bench for seq_pattern_tx.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_tx;

`ifdef PAT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] load_data;
    logic        load_valid;
    logic        load_ready, x, x_valid, busy, done, match;
    logic [7:0]  match_cnt;
    logic        load_ready2, x2, x_valid2, busy2, done2, match2;
    logic [1:0]  match_cnt2;

    int n_cmp = 0;
    int n_err = 0;
    int mc, mp;

    seq_pattern_tx dut (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .x(x), .x_valid(x_valid), .busy(busy),
        .done(done), .match(match), .match_cnt(match_cnt)
    );

    seq_pattern_tx #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready2), .x(x2), .x_valid(x_valid2), .busy(busy2),
        .done(done2), .match(match2), .match_cnt(match_cnt2)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1 chk("rst_busy", busy, 0);
        chk("rst_cnt", match_cnt, 0);
        #3 reset = 1'b1;
        step();
    endtask

    // One isolated word; checks every bit, load_ready and the trailing done.
    task automatic send1(input logic [15:0] w, output int m_cnt, output int m_pos);
        m_cnt = 0;
        m_pos = -1;
        load_data  = w;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("tx_bit", {x_valid, x, done, busy}, {1'b1, w[15-k], 1'b0, 1'b1});
            chk("load_ready", load_ready, (k == 15));
            if (match) begin
                m_cnt++;
                m_pos = k;
            end
            step();
        end
        chk("word_end", {x_valid, x, done, busy, load_ready}, 5'b00101);
        step();
        chk("done_clear", done, 0);
    endtask

    // Two words separated by gap idle cycles (gap=0 means back-to-back).
    task automatic send2(input logic [15:0] w0, input logic [15:0] w1, input int gap,
                         output int m_cnt, output int m_pos);
        logic exp_v, exp_x;
        m_cnt = 0;
        m_pos = -1;
        load_data  = w0;
        load_valid = 1'b1;
        step();
        for (int k = 0; k < 32 + gap; k++) begin
            exp_v = 1'b0;
            exp_x = 1'b0;
            if (k < 16) begin
                exp_v = 1'b1;
                exp_x = w0[15-k];
            end else if (k >= 16 + gap) begin
                exp_v = 1'b1;
                exp_x = w1[31+gap-k];
            end
            chk("stream", {x_valid, x, done}, {exp_v, exp_x, (k == 16)});
            if (match) begin
                m_cnt++;
                m_pos = k;
            end
            if (k == 15 + gap) begin
                load_data  = w1;
                load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            step();
        end
        chk("stream_end", {x_valid, done, busy}, 3'b010);
        step();
    endtask

    initial begin
        reset      = 1'b0;
        load_data  = '0;
        load_valid = 1'b0;

        // Reset values
        #12;
        chk("reset_state", {x, x_valid, busy, done, load_ready}, 5'b00001);
        chk("reset_cnt", match_cnt, 0);
        #3 reset = 1'b1;
        #1 chk("ready_after_rst", load_ready, 1);

        // Single word A5C3: 1010 0101 1100 0011, one 1001 ending at bit 5
        send1(16'hA5C3, mc, mp);
        chk("a5c3_matches", mc, CHK ? 1 : 0);
        chk("a5c3_match_pos", mp, CHK ? 5 : -1);
        chk("a5c3_cnt", match_cnt, CHK ? 1 : 0);

        // Back-to-back 9249 x2: 5 matches per word, none across the boundary
        do_reset();
        send2(16'h9249, 16'h9249, 0, mc, mp);
        chk("b2b_matches", mc, CHK ? 10 : 0);
        chk("b2b_cnt", match_cnt, CHK ? 10 : 0);
        chk("sat_cnt", match_cnt2, CHK ? 3 : 0);
        step();
        chk("sat_hold", match_cnt2, CHK ? 3 : 0);

        // Pattern spanning a word boundary
        do_reset();
        send2(16'h0004, 16'h8000, 0, mc, mp);
        chk("bnd_matches", mc, CHK ? 1 : 0);
        chk("bnd_pos", mp, CHK ? 16 : -1);
        chk("bnd_cnt", match_cnt, CHK ? 1 : 0);

        // Same words with an idle gap: history must be cleared
        do_reset();
        send2(16'h0004, 16'h8000, 3, mc, mp);
        chk("gap_matches", mc, 0);
        chk("gap_cnt", match_cnt, 0);

        // Asynchronous reset during the 6th bit of FFFF
        do_reset();
        load_data  = 16'hFFFF;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (5) step();
        chk("mid_bit6", {x_valid, x, busy}, 3'b111);
        #2 reset = 1'b0;
        #1 chk("mid_rst_out", {x, x_valid, busy, done, load_ready}, 5'b00001);
        chk("mid_rst_cnt", match_cnt, 0);
        step();
        chk("mid_rst_nodone", {done, x_valid}, 2'b00);
        #4 reset = 1'b1;
        #1 chk("mid_ready", load_ready, 1);
        send1(16'h0001, mc, mp);
        chk("post_rst_matches", mc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
